// File: rtl/fir_out_decimator.sv
// fir_out_decimator: FIR output stage. Drops the filter warm-up samples,
// decimates by DECIM, rounds/saturates to DOUT_W bits, and buffers the
// result in a first-word-fall-through FIFO with sticky sat/ovf flags.
`timescale 1ns/1ps
module fir_out_decimator #(
  parameter int DIN_W  = 20,
  parameter int DOUT_W = 10,
  parameter int SHIFT  = 9,   // >= 1
  parameter int DECIM  = 2,   // >= 1, 1 = keep every sample
  parameter int FILL   = 24,  // samples discarded after reset
  parameter int DEPTH  = 8    // power of two, >= 2
) (
  input  logic                       clk,
  input  logic                       rst,        // async, active low
  input  logic [DIN_W-1:0]           din,
  input  logic                       en,
  output logic [DOUT_W-1:0]          dout_data,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       sat_flag,
  output logic                       ovf_flag,
  input  logic                       flag_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (FILL > 1)  ? $clog2(FILL + 1) : 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM)    : 1;

  localparam logic signed [DIN_W:0] HALF = (DIN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [DIN_W:0] QMAX = (DIN_W+1)'((1 << (DOUT_W - 1)) - 1);
  localparam logic signed [DIN_W:0] QMIN = ~QMAX;  // -2^(DOUT_W-1)

  typedef enum logic {WARMUP, RUN} state_t;
  // With no warm-up to discard, reset lands directly in RUN.
  localparam state_t RST_ST = (FILL == 0) ? RUN : WARMUP;

  state_t              state_q, state_d;
  logic [CW-1:0]       warm_cnt_q, warm_cnt_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [DOUT_W-1:0]   r_data_q, r_data_d;
  logic                r_vld_q, r_vld_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]         level_q, level_d;
  logic                sat_flag_q, sat_flag_d;
  logic                ovf_flag_q, ovf_flag_d;
  logic [DEPTH-1:0][DOUT_W-1:0] mem_q, mem_d;

  logic                keep;
  logic signed [DIN_W:0] t_rnd, q_sh;
  logic [DOUT_W-1:0]   rq;
  logic                sat;
  logic                full, empty, rd, wr, ovf_set;

  // Warm-up / decimation sequencing; everything holds while en is low.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    phase_d    = phase_q;
    keep       = 1'b0;
    if (en) begin
      case (state_q)
        WARMUP: begin
          warm_cnt_d = warm_cnt_q + CW'(1);
          if (warm_cnt_q == CW'(FILL - 1)) state_d = RUN;
        end
        RUN: begin
          keep    = (phase_q == '0);
          phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
        end
        default: state_d = RST_ST;
      endcase
    end
  end

  // Round half-up in one extra bit, arithmetic shift, then clamp.
  always_comb begin
    t_rnd = {din[DIN_W-1], din} + HALF;
    q_sh  = t_rnd >>> SHIFT;
    rq    = q_sh[DOUT_W-1:0];
    sat   = 1'b0;
    if (q_sh > QMAX) begin
      rq  = QMAX[DOUT_W-1:0];
      sat = 1'b1;
    end else if (q_sh < QMIN) begin
      rq  = QMIN[DOUT_W-1:0];
      sat = 1'b1;
    end
  end

  // FIFO status; a write into a full FIFO is allowed only alongside a read.
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd      = !empty && dout_ready;
    wr      = r_vld_q && (!full || rd);
    ovf_set = r_vld_q && full && !rd;
  end

  // Next state for the requant register, FIFO pointers, level and flags.
  always_comb begin
    r_data_d = keep ? rq : r_data_q;
    r_vld_d  = keep;
    wr_ptr_d = wr ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({wr, rd})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q[AW-1:0]] = r_data_q;
    // Clear first so a same-edge set wins.
    sat_flag_d = flag_clr ? 1'b0 : sat_flag_q;
    ovf_flag_d = flag_clr ? 1'b0 : ovf_flag_q;
    if (keep && sat) sat_flag_d = 1'b1;
    if (ovf_set)     ovf_flag_d = 1'b1;
  end

  // Control and datapath registers with async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RST_ST;
      warm_cnt_q <= '0;
      phase_q    <= '0;
      r_data_q   <= '0;
      r_vld_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sat_flag_q <= 1'b0;
      ovf_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      phase_q    <= phase_d;
      r_data_q   <= r_data_d;
      r_vld_q    <= r_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sat_flag_q <= sat_flag_d;
      ovf_flag_q <= ovf_flag_d;
    end
  end

  // FIFO storage needs no reset; the output is masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout_valid = !empty;
  assign dout_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign level      = level_q;
  assign sat_flag   = sat_flag_q;
  assign ovf_flag   = ovf_flag_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench: dut_a uses default parameters (warm-up + decimation),
// dut_b uses FILL=0, DECIM=1 (rounding, saturation, FIFO behaviour).
`timescale 1ns/1ps
module tb_fir_out_decimator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] din = '0;
  logic        en = 1'b0, dout_ready = 1'b0, flag_clr = 1'b0;

  logic [9:0]  a_data, b_data;
  logic        a_valid, b_valid;
  logic [3:0]  a_level, b_level;
  logic        a_sat, b_sat, a_ovf, b_ovf;

  fir_out_decimator dut_a (
    .clk(clk), .rst(rst), .din(din), .en(en),
    .dout_data(a_data), .dout_valid(a_valid), .dout_ready(dout_ready),
    .level(a_level), .sat_flag(a_sat), .ovf_flag(a_ovf), .flag_clr(flag_clr));

  fir_out_decimator #(.FILL(0), .DECIM(1)) dut_b (
    .clk(clk), .rst(rst), .din(din), .en(en),
    .dout_data(b_data), .dout_valid(b_valid), .dout_ready(dout_ready),
    .level(b_level), .sat_flag(b_sat), .ovf_flag(b_ovf), .flag_clr(flag_clr));

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int mq[$];
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int v, input bit e);
    din = 20'(v);
    en  = e;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; dout_ready = 1'b0; flag_clr = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  // One kept sample through dut_b: R at first edge, FIFO head after second.
  task automatic one(input int v, input int exp, input string tag);
    put(v, 1'b1);
    put(0, 1'b0);
    chk(tag, int'($signed(b_data)), exp);
    put(0, 1'b0);
  endtask

  // Items popped from dut_a (sampled mid-cycle, popped at the next edge).
  always @(negedge clk)
    if (mon_en && a_valid && dout_ready) mq.push_back(int'($signed(a_data)));

  initial begin
    #1;
    chk("rst_a_valid", int'(a_valid), 0);
    chk("rst_a_data",  int'(a_data),  0);
    chk("rst_b_level", int'(b_level), 0);
    chk("rst_b_flags", int'({b_sat, b_ovf}), 0);

    // Rounding and saturation
    do_reset();
    dout_ready = 1'b1;
    put(1000, 1'b1);
    chk("lat_not_yet", int'(b_valid), 0);
    put(0, 1'b0);
    chk("round_pos", int'($signed(b_data)), 2);
    chk("round_pos_valid", int'(b_valid), 1);
    chk("round_pos_sat", int'(b_sat), 0);
    put(0, 1'b0);
    chk("drained", int'(b_valid), 0);
    one(-1000, -2, "round_neg");
    chk("neg_sat", int'(b_sat), 0);
    one(300000, 511, "sat_pos");
    chk("sat_pos_flag", int'(b_sat), 1);
    one(-300000, -512, "sat_neg");
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("sat_clr", int'(b_sat), 0);
    chk("no_ovf", int'(b_ovf), 0);

    // Warm-up and decimation on dut_a, with an en gap mid-ramp
    do_reset();
    dout_ready = 1'b1;
    mq.delete();
    mon_en = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (n == 25) chk("warm_quiet", mq.size(), 0);
      if (n == 34) for (int g = 0; g < 5; g++) put(300000, 1'b0);
      put(512 * n, 1'b1);
    end
    repeat (4) put(0, 1'b0);
    mon_en = 1'b0;
    chk("dec_count", mq.size(), 13);
    for (int i = 0; i < 13; i++)
      chk($sformatf("dec_%0d", i), (i < mq.size()) ? mq[i] : -9999, 24 + 2 * i);
    chk("dec_sat", int'(a_sat), 0);

    // FIFO full and overflow
    do_reset();
    for (int i = 1; i <= 10; i++) put(512 * i, 1'b1);
    put(0, 1'b0);
    chk("full_level", int'(b_level), 8);
    chk("full_ovf", int'(b_ovf), 1);
    dout_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), int'($signed(b_data)), i);
      tick();
    end
    chk("drain_empty", int'(b_valid), 0);
    chk("drain_level", int'(b_level), 0);

    // Full with simultaneous read and write
    do_reset();
    for (int i = 1; i <= 9; i++) put(512 * i, 1'b1);
    chk("rw_full", int'(b_level), 8);
    dout_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("rw_head_%0d", j), int'($signed(b_data)), 1 + j);
      chk($sformatf("rw_level_%0d", j), int'(b_level), 8);
      put((10 + j) * 512, 1'b1);
    end
    en = 1'b0;
    chk("rw_level_end", int'(b_level), 8);
    chk("rw_head_end", int'($signed(b_data)), 9);
    chk("rw_no_ovf", int'(b_ovf), 0);

    // Asynchronous reset mid-stream, then warm-up again
    do_reset();
    put(300000, 1'b1);
    for (int i = 2; i <= 10; i++) put(512 * i, 1'b1);
    put(0, 1'b0);
    dout_ready = 1'b1;
    repeat (3) tick();
    dout_ready = 1'b0;
    chk("pre_level", int'(b_level), 5);
    chk("pre_flags", int'({b_sat, b_ovf}), 3);
    #2 rst = 1'b0;
    #1;
    chk("arst_b_valid", int'(b_valid), 0);
    chk("arst_b_data",  int'(b_data),  0);
    chk("arst_b_level", int'(b_level), 0);
    chk("arst_b_flags", int'({b_sat, b_ovf}), 0);
    chk("arst_a_flags", int'({a_valid, a_sat, a_ovf}), 0);
    tick();
    rst = 1'b1;
    tick();
    mq.delete();
    dout_ready = 1'b1;
    mon_en = 1'b1;
    for (int n = 0; n < 30; n++) put(512 * n, 1'b1);
    repeat (4) put(0, 1'b0);
    mon_en = 1'b0;
    chk("rewarm_count", mq.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("rewarm_%0d", i), (i < mq.size()) ? mq[i] : -9999, 24 + 2 * i);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
